// File: rtl/mem_hammer_responder_if.sv
// Avalon-style request/response bundle between the memory-test initiator
// and the DRAM-like loopback responder.
interface mem_hammer_responder_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  write;
  logic                  read;
  logic [WORD_WIDTH-1:0] writedata;
  logic                  wait_request;
  logic                  read_data_valid;
  logic [WORD_WIDTH-1:0] readdata;

  modport master (
    output address, write, read, writedata,
    input  wait_request, read_data_valid, readdata
  );

  modport slave (
    input  address, write, read, writedata,
    output wait_request, read_data_valid, readdata
  );
endinterface

// File: rtl/mem_hammer_responder.sv
// DRAM-like loopback responder: open-row timing, refresh, in-order read
// pipeline, per-row activation counting and rowhammer-style bit-flip injection.
//
// state   | meaning
// CLOSED  | no row open; any command latches its row and starts activation
// ACT     | activate penalty, T_ACT cycles, then the latched row opens
// OPEN    | commands to open_row accepted; other rows re-activate
// REFRESH | T_RFC busy cycles; clears activation counters and victim flags
module mem_hammer_responder #(
  parameter int ADDR_WIDTH       = 64,
  parameter int WORD_WIDTH       = 64,
  parameter int ROW_WIDTH        = 12,
  parameter int ROW_POS          = 10,
  parameter int COL_WIDTH        = 10,
  parameter int COL_POS          = 1,
  parameter int MODEL_ROW_BITS   = 4,
  parameter int MODEL_COL_BITS   = 4,
  parameter int READ_LATENCY     = 4,
  parameter int T_ACT            = 3,
  parameter int T_RFC            = 8,
  parameter int REFRESH_INTERVAL = 1024,
  parameter int ACT_CNT_WIDTH    = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  mem_hammer_responder_if.slave    bus,
  input  logic [ACT_CNT_WIDTH-1:0] hammer_threshold_i,
  input  logic                     inject_en_i,
  output logic [ROW_WIDTH-1:0]     open_row_o,
  output logic [31:0]              total_acts_o,
  output logic [31:0]              flips_injected_o,
  output logic [1:0]               state_o
);

  localparam int NROWS   = 1 << MODEL_ROW_BITS;
  localparam int IDX_W   = MODEL_ROW_BITS + MODEL_COL_BITS;
  localparam int NWORDS  = 1 << IDX_W;
  localparam int RI_W    = $clog2(REFRESH_INTERVAL);
  localparam int TMR_MAX = (T_ACT > T_RFC) ? T_ACT : T_RFC;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  localparam logic [RI_W-1:0]           RI_LAST  = RI_W'(REFRESH_INTERVAL - 1);
  localparam logic [TMR_W-1:0]          TACT_LD  = TMR_W'(T_ACT - 1);
  localparam logic [TMR_W-1:0]          TRFC_LD  = TMR_W'(T_RFC - 1);
  localparam logic [MODEL_ROW_BITS-1:0] ROW_ONE  = 1;
  localparam logic [MODEL_ROW_BITS-1:0] ROW_MAX  = '1;
  localparam logic [WORD_WIDTH-1:0]     WORD_ONE = 1;

  typedef enum logic [1:0] {
    S_CLOSED  = 2'd0,
    S_ACT     = 2'd1,
    S_OPEN    = 2'd2,
    S_REFRESH = 2'd3
  } state_e;

  state_e                    state_q;
  logic [TMR_W-1:0]          tmr_q;
  logic [ROW_WIDTH-1:0]      act_row_q;
  logic [ROW_WIDTH-1:0]      open_row_q;
  logic [RI_W-1:0]           rfsh_cnt_q;
  logic                      rfsh_pend_q;
  logic [ACT_CNT_WIDTH-1:0]  act_cnt_q [NROWS];
  logic [NROWS-1:0]          victim_q;
  logic [31:0]               total_acts_q;
  logic [31:0]               flips_q;
  logic [WORD_WIDTH-1:0]     mem_q [NWORDS];
  logic                      pipe_vld_q  [READ_LATENCY];
  logic [WORD_WIDTH-1:0]     pipe_data_q [READ_LATENCY];

  logic [ADDR_WIDTH-1:0]     addr;
  logic [ROW_WIDTH-1:0]      req_row;
  logic [COL_WIDTH-1:0]      req_col;
  logic [MODEL_ROW_BITS-1:0] m_row;
  logic [MODEL_ROW_BITS-1:0] lo_row;
  logic [MODEL_ROW_BITS-1:0] hi_row;
  logic [IDX_W-1:0]          idx;
  logic                      cmd;
  logic                      is_rd;
  logic                      row_hit;
  logic                      wait_req;
  logic                      accept;
  logic                      do_act;
  logic                      do_flip;
  logic                      rfsh_exit;
  logic [ACT_CNT_WIDTH-1:0]  nb_lo;
  logic [ACT_CNT_WIDTH-1:0]  nb_hi;
  logic [ACT_CNT_WIDTH:0]    nb_sum;
  logic [WORD_WIDTH-1:0]     rd_word_d;
  logic                      unused_addr_bits;

  assign addr    = bus.address;
  assign req_row = addr[ROW_POS +: ROW_WIDTH];
  assign req_col = addr[COL_POS +: COL_WIDTH];
  assign m_row   = req_row[MODEL_ROW_BITS-1:0];
  assign lo_row  = m_row - ROW_ONE;
  assign hi_row  = m_row + ROW_ONE;
  assign idx     = {m_row, req_col[MODEL_COL_BITS-1:0]};
  assign unused_addr_bits = ^{addr, req_col};

  // A simultaneous read+write is a write only.
  assign cmd     = bus.read | bus.write;
  assign is_rd   = bus.read & ~bus.write;
  assign row_hit = (req_row == open_row_q);

  always_comb begin
    wait_req = 1'b1;
    if (reset_i && (state_q == S_OPEN) && !rfsh_pend_q && row_hit) begin
      wait_req = 1'b0;
    end
  end

  assign accept    = cmd & ~wait_req;
  assign do_act    = reset_i & cmd & ~rfsh_pend_q &
                     ((state_q == S_CLOSED) | ((state_q == S_OPEN) & ~row_hit));
  assign rfsh_exit = (state_q == S_REFRESH) && (tmr_q == '0);

  // Neighbour sum never wraps between row 0 and the top modelled row.
  assign nb_lo  = (m_row != '0)     ? act_cnt_q[lo_row] : '0;
  assign nb_hi  = (m_row != ROW_MAX) ? act_cnt_q[hi_row] : '0;
  assign nb_sum = {1'b0, nb_lo} + {1'b0, nb_hi};

  assign do_flip = accept & is_rd & inject_en_i & (hammer_threshold_i != '0) &
                   (nb_sum >= {1'b0, hammer_threshold_i}) & ~victim_q[m_row];

  assign rd_word_d = mem_q[idx] ^ (do_flip ? WORD_ONE : '0);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= S_CLOSED;
      tmr_q      <= '0;
      act_row_q  <= '0;
      open_row_q <= '0;
    end else begin
      case (state_q)
        S_CLOSED, S_OPEN: begin
          if (rfsh_pend_q) begin
            state_q <= S_REFRESH;
            tmr_q   <= TRFC_LD;
          end else if (do_act) begin
            state_q   <= S_ACT;
            tmr_q     <= TACT_LD;
            act_row_q <= req_row;
          end
        end
        S_ACT: begin
          if (tmr_q == '0) begin
            state_q    <= S_OPEN;
            open_row_q <= act_row_q;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        default: begin
          if (tmr_q == '0) begin
            state_q <= S_CLOSED;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
      endcase
    end
  end

  // Pending refresh is only honoured from CLOSED/OPEN, so it rides out ACT.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rfsh_cnt_q  <= '0;
      rfsh_pend_q <= 1'b0;
    end else begin
      if (rfsh_cnt_q == RI_LAST) begin
        rfsh_cnt_q  <= '0;
        rfsh_pend_q <= 1'b1;
      end else begin
        rfsh_cnt_q <= rfsh_cnt_q + 1'b1;
        if (rfsh_exit) begin
          rfsh_pend_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i || rfsh_exit) begin
      for (int i = 0; i < NROWS; i++) begin
        act_cnt_q[i] <= '0;
      end
      victim_q <= '0;
    end else begin
      if (do_act && (act_cnt_q[m_row] != '1)) begin
        act_cnt_q[m_row] <= act_cnt_q[m_row] + 1'b1;
      end
      if (do_flip) begin
        victim_q[m_row] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      total_acts_q <= '0;
      flips_q      <= '0;
    end else begin
      if (do_act && (total_acts_q != '1)) begin
        total_acts_q <= total_acts_q + 32'd1;
      end
      if (do_flip && (flips_q != '1)) begin
        flips_q <= flips_q + 32'd1;
      end
    end
  end

  // Storage is deliberately left uninitialised across reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      if (bus.write) begin
        mem_q[idx] <= bus.writedata;
      end else if (do_flip) begin
        mem_q[idx] <= rd_word_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= accept & is_rd;
      if (accept && is_rd) begin
        pipe_data_q[0] <= rd_word_d;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  assign bus.wait_request    = wait_req;
  assign bus.read_data_valid = pipe_vld_q[READ_LATENCY-1];
  assign bus.readdata        = pipe_data_q[READ_LATENCY-1];
  assign open_row_o          = open_row_q;
  assign total_acts_o        = total_acts_q;
  assign flips_injected_o    = flips_q;
  assign state_o             = state_q;

endmodule
